// File: rtl/echo_tap_scheduler.sv
// echo_tap_scheduler: sequences a stereo ring-buffer delay RAM to build a
// multi-tap echo. Each accepted sample is written once, then the single read
// port is time-shared across NUM_TAPS taps. The attenuated taps are summed
// onto the dry sample, and one mixed stereo sample is emitted.
//
// Build option: define ECHO_TAP_SATURATE_EN to clamp the final mix to the
// DATA_WIDTH signed range. Without it, the mix wraps in two's complement.
// Both builds have identical timing.
module echo_tap_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_TAPS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic [DATA_WIDTH-1:0]          sample_left,
    input  logic [DATA_WIDTH-1:0]          sample_right,
    input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay,
    input  logic [NUM_TAPS*3-1:0]          tap_shift,
    input  logic [NUM_TAPS-1:0]            tap_enable,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_waddr,
    output logic [2*DATA_WIDTH-1:0]        ram_wdata,
    output logic [ADDR_WIDTH-1:0]          ram_raddr,
    input  logic [2*DATA_WIDTH-1:0]        ram_rdata,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_left,
    output logic [DATA_WIDTH-1:0]          out_right,
    output logic                           busy,
    output logic                           overrun
);

    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int EXT_W = ACC_W - DATA_WIDTH;
    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(EXT_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    logic [ADDR_WIDTH-1:0]          wr_ptr;
    logic [TAP_W-1:0]               tap_idx;
    logic [TAP_W-1:0]               tap_nxt;
    logic [TAP_W-1:0]               rd_tap;
    logic                           rd_pending;
    logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_q;
    logic [NUM_TAPS*3-1:0]          shift_q;
    logic [NUM_TAPS-1:0]            en_q;

    logic [ADDR_WIDTH-1:0]   sel_delay;
    logic [2:0]              sel_shift;
    logic                    sel_en;
    logic [ADDR_WIDTH-1:0]   raddr_nxt;

    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic signed [ACC_W-1:0] ext_l, ext_r;
    logic signed [ACC_W-1:0] shifted_l, shifted_r;
    logic signed [ACC_W-1:0] add_l, add_r;
    logic signed [ACC_W-1:0] acc_l_nxt, acc_r_nxt;

    // Reduce the wide accumulator to an output sample (clamp or wrap).
    function automatic logic [DATA_WIDTH-1:0] limit(input logic signed [ACC_W-1:0] a);
`ifdef ECHO_TAP_SATURATE_EN
        if (a > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end
        return a[DATA_WIDTH-1:0];
`else
        return a[DATA_WIDTH-1:0];
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; samples are accepted only from IDLE.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_READ;
            S_READ:  if (tap_idx == LAST_TAP) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Select the next read tap's delay and the shift/enable of the tap whose data is returning.
    always_comb begin
        tap_nxt   = (state == S_WRITE) ? '0 : tap_idx + 1'b1;
        sel_delay = '0;
        sel_shift = '0;
        sel_en    = 1'b0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if (tap_nxt == TAP_W'(t)) begin
                sel_delay = delay_q[t*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (rd_tap == TAP_W'(t)) begin
                sel_shift = shift_q[t*3 +: 3];
                sel_en    = en_q[t];
            end
        end
        raddr_nxt = wr_ptr - sel_delay;
    end

    // Attenuate the returning tap and add it to the running mix.
    always_comb begin
        ext_l     = {{EXT_W{ram_rdata[2*DATA_WIDTH-1]}}, ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH]};
        ext_r     = {{EXT_W{ram_rdata[DATA_WIDTH-1]}}, ram_rdata[DATA_WIDTH-1:0]};
        shifted_l = ext_l >>> sel_shift;
        shifted_r = ext_r >>> sel_shift;
        if (rd_pending && sel_en) begin
            add_l = shifted_l;
            add_r = shifted_r;
        end else begin
            add_l = '0;
            add_r = '0;
        end
        acc_l_nxt = acc_l + add_l;
        acc_r_nxt = acc_r + add_r;
    end

    // Datapath: RAM sequencing, accumulation, output registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            tap_idx    <= '0;
            rd_tap     <= '0;
            rd_pending <= 1'b0;
            delay_q    <= '0;
            shift_q    <= '0;
            en_q       <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_raddr  <= '0;
            out_valid  <= 1'b0;
            out_left   <= '0;
            out_right  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= sample_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        delay_q   <= tap_delay;
                        shift_q   <= tap_shift;
                        en_q      <= tap_enable;
                        acc_l     <= {{EXT_W{sample_left[DATA_WIDTH-1]}}, sample_left};
                        acc_r     <= {{EXT_W{sample_right[DATA_WIDTH-1]}}, sample_right};
                        ram_we    <= 1'b1;
                        ram_waddr <= wr_ptr;
                        ram_wdata <= {sample_left, sample_right};
                        busy      <= 1'b1;
                    end
                end
                S_WRITE: begin
                    ram_we     <= 1'b0;
                    tap_idx    <= '0;
                    rd_pending <= 1'b0;
                    ram_raddr  <= raddr_nxt;
                end
                S_READ: begin
                    rd_pending <= 1'b1;
                    rd_tap     <= tap_idx;
                    acc_l      <= acc_l_nxt;
                    acc_r      <= acc_r_nxt;
                    if (tap_idx != LAST_TAP) begin
                        tap_idx   <= tap_nxt;
                        ram_raddr <= raddr_nxt;
                    end
                end
                S_DRAIN: begin
                    rd_pending <= 1'b0;
                    acc_l      <= acc_l_nxt;
                    acc_r      <= acc_r_nxt;
                    wr_ptr     <= wr_ptr + 1'b1;
                    out_left   <= limit(acc_l_nxt);
                    out_right  <= limit(acc_r_nxt);
                    out_valid  <= 1'b1;
                end
                S_OUT: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Testbench for echo_tap_scheduler (NUM_TAPS=2, ADDR_WIDTH=5, DATA_WIDTH=16).
// A behavioural RAM sits on the RAM ports. Expected mixes come from hand
// tables for the directed cases. For random stimulus, they come from a sample
// history model.
module tb_echo_tap_scheduler;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int NT  = 2;
    localparam int TDW = NT * AW;
    localparam int TSW = NT * 3;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sample_valid;
    logic [DW-1:0]   sample_left, sample_right;
    logic [TDW-1:0]  tap_delay;
    logic [TSW-1:0]  tap_shift;
    logic [NT-1:0]   tap_enable;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [2*DW-1:0] ram_wdata, ram_rdata;
    logic            out_valid;
    logic [DW-1:0]   out_left, out_right;
    logic            busy, overrun;

    always #5 clk = ~clk;

    echo_tap_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TAPS(NT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .tap_delay    (tap_delay),
        .tap_shift    (tap_shift),
        .tap_enable   (tap_enable),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .out_valid    (out_valid),
        .out_left     (out_left),
        .out_right    (out_right),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Delay RAM: one write port, registered read port (latency 1).
    logic [2*DW-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Samples accepted since the last reset, oldest first.
    int hist_l[$];
    int hist_r[$];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int fold(input int v);
`ifdef ECHO_TAP_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int w;
        w = v & 32'h0000FFFF;
        return (w >= 32768) ? w - 65536 : w;
`endif
    endfunction

    // Tap contribution for sample index n: history d samples back, attenuated.
    // Locations never written since reset read as zero from the bench RAM.
    function automatic int tap_of(input int n, input int d, input int s, input bit e, input bit left);
        int h;
        if (!e) return 0;
        if (n - d < 0) h = 0;
        else h = left ? hist_l[n-d] : hist_r[n-d];
        return h >>> s;
    endfunction

    // Apply one sample and watch 8 cycles after accept. Optionally inject a
    // stray strobe in cycle ovr_at. Check the mix, timing and RAM traffic.
    task automatic run_sample(input string name, input int l, input int r,
                              input int d0, input int d1, input int s0, input int s1,
                              input int en, input int ovr_at,
                              input bit use_tab, input int tab_l, input int tab_r);
        int n, exp_l, exp_r, lat, ov_cnt, we_cnt, ovr_cnt, busy_bad;
        int got_l, got_r, wa, wd_l, wd_r, ra0;
        n = hist_l.size();
        hist_l.push_back(l);
        hist_r.push_back(r);
        if (use_tab) begin
            exp_l = tab_l;
            exp_r = tab_r;
        end else begin
            exp_l = fold(l + tap_of(n, d0, s0, en[0], 1'b1) + tap_of(n, d1, s1, en[1], 1'b1));
            exp_r = fold(r + tap_of(n, d0, s0, en[0], 1'b0) + tap_of(n, d1, s1, en[1], 1'b0));
        end
        lat = -1; ov_cnt = 0; we_cnt = 0; ovr_cnt = 0; busy_bad = 0;
        got_l = 0; got_r = 0; wa = -1; wd_l = 0; wd_r = 0; ra0 = -1;

        @(negedge clk);
        sample_left  = DW'(l);
        sample_right = DW'(r);
        tap_delay    = {AW'(d1), AW'(d0)};
        tap_shift    = {3'(s1), 3'(s0)};
        tap_enable   = NT'(en);
        sample_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                wa   = int'(ram_waddr);
                wd_l = int'($signed(ram_wdata[2*DW-1:DW]));
                wd_r = int'($signed(ram_wdata[DW-1:0]));
            end
            if (k == 2) ra0 = int'(ram_raddr);
            if (overrun) ovr_cnt++;
            if (busy !== (k <= 5)) busy_bad++;
            if (out_valid) begin
                ov_cnt++;
                if (lat < 0) begin
                    lat   = k;
                    got_l = int'($signed(out_left));
                    got_r = int'($signed(out_right));
                end
            end
            // Inputs are scrambled after accept; the DUT must use its latched copy.
            sample_valid = (k == ovr_at);
            sample_left  = DW'($urandom);
            sample_right = DW'($urandom);
            tap_delay    = TDW'($urandom);
            tap_shift    = TSW'($urandom);
            tap_enable   = NT'($urandom);
        end
        sample_valid = 1'b0;

        check({name, " latency"}, lat, 5);
        check({name, " out_valid count"}, ov_cnt, 1);
        check({name, " out_left"}, got_l, exp_l);
        check({name, " out_right"}, got_r, exp_r);
        check({name, " ram write count"}, we_cnt, 1);
        check({name, " ram_waddr"}, wa, n % DEPTH);
        check({name, " ram_wdata left"}, wd_l, l);
        check({name, " ram_wdata right"}, wd_r, r);
        check({name, " tap0 ram_raddr"}, ra0, ((n - d0) % DEPTH + DEPTH) % DEPTH);
        check({name, " overrun pulses"}, ovr_cnt, (ovr_at > 0) ? 1 : 0);
        check({name, " busy window errors"}, busy_bad, 0);
    endtask

    typedef struct {
        int l, r, d0, d1, s0, s1, en, ovr_at;
        int exp_l, exp_r;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, en;
        int ovr_seen, ov_seen, busy_seen;

        // Directed vectors, applied right after a reset (history empty).
        vecs[0] = '{l: 1000,  r: 1000,   d0: 1, d1: 0, s0: 1, s1: 0, en: 1, ovr_at: 0, exp_l: 1000, exp_r: 1000};
        vecs[1] = '{l: 2000,  r: 2000,   d0: 1, d1: 0, s0: 1, s1: 0, en: 1, ovr_at: 0, exp_l: 2500, exp_r: 2500};
        vecs[2] = '{l: 3000,  r: 3000,   d0: 1, d1: 0, s0: 1, s1: 0, en: 1, ovr_at: 3, exp_l: 4000, exp_r: 4000};
        vecs[3] = '{l: 4000,  r: 4000,   d0: 1, d1: 0, s0: 1, s1: 0, en: 1, ovr_at: 0, exp_l: 5500, exp_r: 5500};
        vecs[4] = '{l: 1234,  r: 1234,   d0: 0, d1: 0, s0: 0, s1: 0, en: 1, ovr_at: 5, exp_l: 2468, exp_r: 2468};
`ifdef ECHO_TAP_SATURATE_EN
        vecs[5] = '{l: 20000, r: -20000, d0: 0, d1: 0, s0: 0, s1: 0, en: 3, ovr_at: 0, exp_l: 32767, exp_r: -32768};
`else
        vecs[5] = '{l: 20000, r: -20000, d0: 0, d1: 0, s0: 0, s1: 0, en: 3, ovr_at: 0, exp_l: -5536, exp_r: 5536};
`endif
        vecs[6] = '{l: -800,  r: 800,    d0: 1, d1: 2, s0: 2, s1: 3, en: 3, ovr_at: 0, exp_l: 4354, exp_r: -4046};

        rst_n = 1'b0;
        sample_valid = 1'b0;
        sample_left = '0; sample_right = '0;
        tap_delay = '0; tap_shift = '0; tap_enable = '0;
        repeat (3) @(negedge clk);

        check("reset out_valid", int'(out_valid), 0);
        check("reset out_left", int'(out_left), 0);
        check("reset out_right", int'(out_right), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        check("reset ram_we", int'(ram_we), 0);
        check("reset ram_waddr", int'(ram_waddr), 0);
        check("reset ram_raddr", int'(ram_raddr), 0);
        check("reset ram_wdata", int'(ram_wdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Dry-only sample: no taps enabled.
        run_sample("dry", 100, -100, 0, 0, 0, 0, 0, 0, 1'b1, 100, -100);

        // Reset again so the echo sequence starts at write address 0.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        hist_l.delete();
        hist_r.delete();
        check("re-reset ram_waddr", int'(ram_waddr), 0);

        for (int i = 0; i < 7; i++) begin
            run_sample($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].d0, vecs[i].d1,
                       vecs[i].s0, vecs[i].s1, vecs[i].en, vecs[i].ovr_at,
                       1'b1, vecs[i].exp_l, vecs[i].exp_r);
        end

        // Random samples checked against the history model. This crosses the
        // write-pointer wrap, and sample 33 uses a 31-sample tap-0 delay.
        for (int i = 0; i < 40; i++) begin
            d0 = int'($urandom_range(0, 31));
            d1 = int'($urandom_range(0, 31));
            en = int'($urandom_range(0, 3));
            if (hist_l.size() == 33) begin
                d0 = 31;
                en = en | 1;
            end
            run_sample($sformatf("rand%0d", i),
                       int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                       d0, d1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), en,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 0,
                       1'b0, 0, 0);
        end

        // Reset asserted two cycles after accept: the sample is lost.
        @(negedge clk);
        sample_left = DW'(7777); sample_right = DW'(7777);
        tap_delay = '0; tap_shift = '0; tap_enable = '1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check("pre-reset busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", int'(busy), 0);
        check("async reset ram_raddr", int'(ram_raddr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0; ovr_seen = 0; busy_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
            if (overrun) ovr_seen++;
            if (busy) busy_seen++;
        end
        check("mid-reset out_valid count", ov_seen, 0);
        check("mid-reset overrun count", ovr_seen, 0);
        check("mid-reset busy count", busy_seen, 0);
        check("mid-reset out_left", int'(out_left), 0);
        check("mid-reset out_right", int'(out_right), 0);
        check("mid-reset ram_we", int'(ram_we), 0);
        check("mid-reset ram_waddr", int'(ram_waddr), 0);
        check("mid-reset ram_wdata", int'(ram_wdata), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_tap_scheduler.md
Name: echo_tap_scheduler

Overview:
- Sequencer for the stereo ring-buffer delay RAM (one write port, one registered read port, read latency 1, 2*DATA_WIDTH words).
- On each accepted input sample it writes the left/right pair into the ring buffer.
- It then time-multiplexes the read port across NUM_TAPS configurable delay taps.
- It sums the dry sample with the attenuated taps and emits one mixed stereo sample, so the audio path gets a multi-tap echo from a single RAM.

Parameters:
- DATA_WIDTH, 16: bits per channel sample (signed two's complement).
- ADDR_WIDTH, 5: ring-buffer address width; depth = 2**ADDR_WIDTH.
- NUM_TAPS, 4: number of delay taps serviced per sample (1..8).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe: new sample on sample_left/sample_right.
- sample_left  in  DATA_WIDTH  signed left input.
- sample_right  in  DATA_WIDTH  signed right input.
- tap_delay  in  NUM_TAPS*ADDR_WIDTH  packed per-tap delay in samples; tap i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- tap_shift  in  NUM_TAPS*3  packed per-tap attenuation; the tap value is arithmetic-shifted right by this amount.
- tap_enable  in  NUM_TAPS  per-tap enable; a disabled tap contributes 0 but still takes its slot.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  2*DATA_WIDTH  {left,right} write data.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_rdata  in  2*DATA_WIDTH  {left,right} registered read data; valid one cycle after ram_raddr.
- out_valid  out  1  one-cycle strobe: mixed sample ready.
- out_left  out  DATA_WIDTH  mixed left output.
- out_right  out  DATA_WIDTH  mixed right output.
- busy  out  1  high from accept until the out_valid cycle inclusive.
- overrun  out  1  one-cycle pulse when sample_valid arrives while busy.

Behaviour:
- Reset values (async, rst_n low): state IDLE; wr_ptr=0; accumulators 0; ram_we=0; ram_waddr=0; ram_raddr=0; ram_wdata=0; out_valid=0; out_left=0; out_right=0; busy=0; overrun=0. RAM contents are not cleared.
- FSM states: IDLE, WRITE, READ, DRAIN, OUT.
- IDLE, sample_valid=1 (accept, cycle 0):
  - latch the sample, tap_delay, tap_shift and tap_enable;
  - acc_l/acc_r = sign-extended dry sample;
  - busy=1; go to WRITE.
- WRITE (cycle 1): ram_we=1, ram_waddr=wr_ptr, ram_wdata={left,right}; tap index i=0; go to READ.
- READ (cycles 2..NUM_TAPS+1):
  - ram_raddr = wr_ptr - tap_delay[i], modulo 2**ADDR_WIDTH;
  - from the second READ cycle on, accumulate ram_rdata for tap i-1;
  - i increments; after the last tap go to DRAIN.
- DRAIN (cycle NUM_TAPS+2): accumulate the last tap's ram_rdata; wr_ptr increments (wraps 2**ADDR_WIDTH-1 -> 0); go to OUT.
- OUT (cycle NUM_TAPS+3):
  - out_left/out_right register the limited accumulators; out_valid=1; busy=1 this cycle;
  - next state IDLE.
- Latency: sample_valid to out_valid = NUM_TAPS+3 cycles. Minimum sample spacing = NUM_TAPS+4 cycles.
- Accumulate rule: acc += enable[i] ? (sign-extended channel >>> shift[i]) : 0.
- Accumulator width: DATA_WIDTH+4 signed; no intermediate overflow for NUM_TAPS ≤ 8.
- tap_delay=0 returns the current sample: the write in WRITE precedes the read, giving read-after-write.
- Delays larger than the samples written since reset return stale/unknown RAM data; this is accepted behaviour.
- sample_valid while busy (including during OUT): sample dropped, overrun pulses for 1 cycle, FSM unaffected.
- Outputs out_left/out_right hold their value between out_valid strobes.
- rst_n asserted mid-operation: immediate return to reset values; the in-flight sample is lost; no out_valid.

Optional Feature:
- Macro ECHO_TAP_SATURATE_EN.
- Defined: the final accumulator is clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] before output.
- Undefined: the output takes the low DATA_WIDTH bits of the accumulator (two's-complement wrap).
- Timing and latency are identical in both builds.

Test Plan (NUM_TAPS=2, ADDR_WIDTH=5, DATA_WIDTH=16):
- Reset, then sample L=100/R=-100 with tap_enable=00 -> out_valid 5 cycles after the strobe; out=100/-100; one RAM write at addr 0.
- Feed 4 samples L=R={1000,2000,3000,4000}; tap0 delay=1, shift=1, enabled -> 4th output = 4000+1500 = 5500; ram_raddr = 2 during the tap0 slot.
- tap0 delay=0, shift=0, enabled; input L=R=1234 -> out=2468, confirming read-after-write.
- Write 33 samples, then delay=31 -> ram_raddr = (wr_ptr-31) mod 32 with correct wrap; ram_waddr goes 31 -> 0 -> 1.
- Two taps delay=0, shift=0 on input L=R=20000:
  - with ECHO_TAP_SATURATE_EN -> out 32767;
  - without it -> out = 60000 mod 2**16 as signed = -5536.
- sample_valid at accept+3 -> dropped, overrun high exactly 1 cycle, out_valid still at accept+5; rst_n pulsed at accept+2 -> no out_valid, all outputs 0.
